// File: rtl/axis_pkt_pkg.sv
// axis_pkt_pkg: shared types and constants for the packetmem stream forwarder and snooper
package axis_pkt_pkg;
  typedef enum logic [1:0] {ST_WAIT, ST_RECV, ST_DRAIN} snp_state_e;
  localparam int AXIS_DATA_WIDTH = 64;
  localparam int BYTES_PER_WORD = AXIS_DATA_WIDTH / 8;
  typedef logic [31:0] len_t;
endpackage

// File: rtl/axis_keep_popcount.sv
// axis_keep_popcount: combinational count of set TKEEP bits
//   keep_i  [N-1:0]          byte-enable mask
//   cnt_o   [$clog2(N+1)-1:0] number of ones in keep_i
module axis_keep_popcount #(
  parameter int N = 8
) (
  input  logic [N-1:0]           keep_i,
  output logic [$clog2(N+1)-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) cnt_o = cnt_o + $bits(cnt_o)'(keep_i[i]);
  end
endmodule

// File: rtl/axistream_snooper.sv
// axistream_snooper: AXI Stream receive engine writing packets into a free packetmem buffer
//   clk, rst            clock, synchronous active-high reset
//   TDATA/TVALID/TLAST  inbound stream beat; TREADY back to the master
//   TKEEP               byte enables, present only with AXIS_SNOOPER_TKEEP_EN defined
//   snooper_wr_*        packetmem write port (address, data, strobe)
//   snooper_done        1-cycle pulse when a packet has been fully written
//   len_from_snooper    packet length (words, or bytes with TKEEP), valid with snooper_done
//   ready_for_snooper   packetmem has a free buffer, sampled only while waiting
module axistream_snooper
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] TDATA,
  input  logic                  TVALID,
  input  logic                  TLAST,
`ifdef AXIS_SNOOPER_TKEEP_EN
  input  logic [DATA_WIDTH/8-1:0] TKEEP,
`endif
  output logic                  TREADY,
  output logic [ADDR_WIDTH-1:0] snooper_wr_addr,
  output logic [DATA_WIDTH-1:0] snooper_wr_data,
  output logic                  snooper_wr_en,
  output logic                  snooper_done,
  input  logic                  ready_for_snooper,
  output logic [31:0]           len_from_snooper
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};
  snp_state_e state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, done_q, done_d;
  len_t len_q, len_d, last_len;
`ifdef AXIS_SNOOPER_TKEEP_EN
  logic [$clog2(BPW+1)-1:0] keep_cnt;
  axis_keep_popcount #(.N(BPW)) u_keep_popcount (
    .keep_i(TKEEP),
    .cnt_o (keep_cnt)
  );
  // cnt_q counts full words written before this last beat
  assign last_len = len_t'(cnt_q) * len_t'(BPW) + len_t'(keep_cnt);
`else
  assign last_len = len_t'(cnt_q) + len_t'(1);
`endif
  // TREADY depends on state only, never on TVALID
  assign TREADY = state_q != ST_WAIT;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_en_d = 1'b0;
    done_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_d = len_q;
    case (state_q)
      // done_q blocks a ready seen in the same cycle as the completion pulse
      ST_WAIT: if (ready_for_snooper && !done_q) begin
        state_d = ST_RECV;
        cnt_d = '0;
      end
      ST_RECV: if (TVALID) begin
        wr_en_d = 1'b1;
        wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
        wr_data_d = TDATA;
        cnt_d = cnt_q + 1'b1;
        if (TLAST) begin
          done_d = 1'b1;
          len_d = last_len;
          state_d = ST_WAIT;
        end else if (cnt_q == LAST_SLOT) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = TVALID && TLAST ? ST_WAIT : ST_DRAIN;
      default: state_d = ST_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
      cnt_q <= '0;
      wr_en_q <= 1'b0;
      done_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_en_q <= wr_en_d;
      done_q <= done_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_q <= len_d;
    end
  end
  assign snooper_wr_en = wr_en_q;
  assign snooper_wr_addr = wr_addr_q;
  assign snooper_wr_data = wr_data_q;
  assign snooper_done = done_q;
  assign len_from_snooper = len_q;
endmodule

// File: tb/tb_axistream_snooper.sv
// tb_axistream_snooper: table, directed and randomized checks of axistream_snooper
module tb_axistream_snooper;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int CAP = 1 << AW;
  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] TDATA;
  logic TVALID, TLAST, TREADY;
  logic [AW-1:0] snooper_wr_addr;
  logic [DW-1:0] snooper_wr_data;
  logic snooper_wr_en, snooper_done, ready_for_snooper;
  logic [31:0] len_from_snooper;
`ifdef AXIS_SNOOPER_TKEEP_EN
  logic [DW/8-1:0] TKEEP;
  logic [DW/8-1:0] keep_v = '1;
`endif
  axistream_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .TDATA(TDATA),
    .TVALID(TVALID),
    .TLAST(TLAST),
`ifdef AXIS_SNOOPER_TKEEP_EN
    .TKEEP(TKEEP),
`endif
    .TREADY(TREADY),
    .snooper_wr_addr(snooper_wr_addr),
    .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en),
    .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .len_from_snooper(len_from_snooper)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  // reference model: mode 0 idle, 1 receiving, 2 discarding an oversize packet
  int m_mode = 0;
  int m_cnt = 0;
  bit e_wr_en, e_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [31:0] e_len;
  typedef struct {
    bit v, l, rf;
    logic [DW-1:0] d;
    bit tr, we, dn;
    logic [AW-1:0] a;
    logic [31:0] len;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic tick(input bit r, input bit v, input bit l, input bit rf, input logic [DW-1:0] d);
    bit acc, was_done;
    rst = r;
    TVALID = v;
    TLAST = l;
    ready_for_snooper = rf;
    TDATA = d;
`ifdef AXIS_SNOOPER_TKEEP_EN
    TKEEP = keep_v;
`endif
    acc = v && m_mode != 0;
    was_done = e_done;
    e_wr_en = 0;
    e_done = 0;
    if (r) begin
      m_mode = 0;
      m_cnt = 0;
      e_addr = '0;
      e_data = '0;
      e_len = '0;
    end else if (m_mode == 0) begin
      if (rf && !was_done) begin
        m_mode = 1;
        m_cnt = 0;
      end
    end else if (m_mode == 1) begin
      if (acc) begin
        e_wr_en = 1;
        e_addr = AW'(m_cnt);
        e_data = d;
        if (l) begin
          e_done = 1;
`ifdef AXIS_SNOOPER_TKEEP_EN
          e_len = 32'(8 * m_cnt + $countones(keep_v));
`else
          e_len = 32'(m_cnt + 1);
`endif
          m_mode = 0;
        end else if (m_cnt == CAP - 1) begin
          m_mode = 2;
        end
        m_cnt++;
      end
    end else if (acc && l) begin
      m_mode = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("tready", TREADY, m_mode != 0);
    chk("wr_en", snooper_wr_en, e_wr_en);
    chk("done", snooper_done, e_done);
    chk("wr_addr", snooper_wr_addr, e_addr);
    chk("wr_data", snooper_wr_data, e_data);
    chk("len", len_from_snooper, e_len);
  endtask
  task automatic packet(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) tick(0, 0, 0, 0, 64'hdead);
      tick(0, 1, i == n - 1, 0, 64'h1000 + 64'(i));
    end
  endtask
  initial begin
    int writes;
    tbl[0] = '{v: 0, l: 0, rf: 1, d: 0, tr: 1, we: 0, dn: 0, a: 0, len: 0};
    for (int i = 1; i <= 10; i++)
      tbl[i] = '{v: 1, l: i == 10, rf: 0, d: 64'(i - 1), tr: i != 10, we: 1, dn: i == 10,
                 a: AW'(i - 1), len: (i == 10) ? 32'd10 : 32'd0};
    tbl[11] = '{v: 0, l: 0, rf: 0, d: 0, tr: 0, we: 0, dn: 0, a: 9, len: 10};
    @(negedge clk);
    tick(1, 1, 0, 1, 64'hffff);
    tick(1, 0, 0, 0, 0);
    chk("reset_len", len_from_snooper, 0);
    for (int i = 0; i < 12; i++) begin
      tick(0, tbl[i].v, tbl[i].l, tbl[i].rf, tbl[i].d);
      chk("tbl_tready", TREADY, tbl[i].tr);
      chk("tbl_wr_en", snooper_wr_en, tbl[i].we);
      chk("tbl_done", snooper_done, tbl[i].dn);
      chk("tbl_addr", snooper_wr_addr, tbl[i].a);
      chk("tbl_len", len_from_snooper, tbl[i].len);
      if (tbl[i].we) chk("tbl_data", snooper_wr_data, tbl[i].d);
    end
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 64'h55);
    tick(0, 1, 0, 1, 64'h77);
    packet(3, 0);
    chk("bp_len", len_from_snooper, 3);
    tick(0, 0, 0, 1, 0);
    chk("done_rdy_ignored", TREADY, 0);
    tick(0, 0, 0, 1, 0);
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, i == 3, 0, 64'hb0 + 64'(i));
      writes += int'(snooper_wr_en);
      tick(0, 0, 0, 0, 0);
      writes += int'(snooper_wr_en);
    end
    chk("bubble_writes", 64'(writes), 4);
    tick(0, 0, 0, 1, 0);
    writes = 0;
    for (int i = 0; i < CAP + 4; i++) begin
      tick(0, 1, i == CAP + 3, 0, 64'hc00 + 64'(i));
      writes += int'(snooper_wr_en);
      chk("ovf_no_done", snooper_done, 0);
    end
    chk("ovf_writes", 64'(writes), CAP);
    tick(0, 0, 0, 1, 0);
    packet(2, 0);
    chk("after_ovf_len", len_from_snooper, 2);
    tick(0, 0, 0, 1, 0);
    packet(3, 0);
    tick(1, 1, 0, 0, 64'h3);
    chk("rst_wr_en", snooper_wr_en, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 64'h4 + 64'(i));
    tick(0, 1, 0, 1, 64'h7);
    packet(2, 1);
`ifdef AXIS_SNOOPER_TKEEP_EN
    tick(0, 0, 0, 1, 0);
    keep_v = 8'hff;
    tick(0, 1, 0, 0, 64'ha);
    tick(0, 1, 0, 0, 64'hb);
    keep_v = 8'h0f;
    tick(0, 1, 1, 0, 64'hc);
    chk("tkeep_len", len_from_snooper, 20);
    keep_v = 8'hff;
`endif
    for (int i = 0; i < 3000; i++) begin
`ifdef AXIS_SNOOPER_TKEEP_EN
      keep_v = 8'($urandom);
`endif
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           1'($urandom_range(0, 1)), {$urandom, $urandom});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
